// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port external SRAM arbiter.
package sram_arbiter_pkg;

   // Width of the per-phase strobe down-counter (supports up to 15 wait cycles).
   localparam int unsigned WAIT_W = 4;

   // Active-low strobe levels.
   localparam logic STROBE_OFF = 1'b1;
   localparam logic STROBE_ON  = 1'b0;

   // Access sequencer states; each word access is two halfword phases, low first.
   typedef enum logic [2:0] {
      StIdle,
      StSetupLo,
      StStrobeLo,
      StSetupHi,
      StStrobeHi,
      StResp
   } state_e;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, on contention the port
// that was not granted last time wins.
module sram_arb_rr (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);

   // One-hot grant, only while the sequencer can take a new command.
   always_comb begin
      grant_o = 2'b00;
      if (enable_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and halfword access sequencer for a 16-bit asynchronous
// SRAM. Every 32-bit word access runs as a low then a high halfword phase;
// halves with no enabled bytes are skipped on writes. All pad outputs are
// registered so the strobes are glitch-free.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic               CLK,
   input  logic               reset_in,
   input  logic               p0_cmd_valid,
   output logic               p0_cmd_ready,
   input  logic               p0_cmd_write,
   input  logic [SRAM_AW-2:0] p0_cmd_addr,
   input  logic [31:0]        p0_cmd_wdata,
   input  logic [3:0]         p0_cmd_mask,
   output logic               p0_rsp_valid,
   output logic [31:0]        p0_rsp_rdata,
   input  logic               p1_cmd_valid,
   output logic               p1_cmd_ready,
   input  logic               p1_cmd_write,
   input  logic [SRAM_AW-2:0] p1_cmd_addr,
   input  logic [31:0]        p1_cmd_wdata,
   input  logic [3:0]         p1_cmd_mask,
   output logic               p1_rsp_valid,
   output logic [31:0]        p1_rsp_rdata,
   output logic [SRAM_AW-1:0] sram_addr,
   input  logic [15:0]        sram_dat_read,
   output logic [15:0]        sram_dat_write,
   output logic               sram_dat_writeEnable,
   output logic               sram_cs_n,
   output logic               sram_we_n,
   output logic               sram_oe_n,
   output logic               sram_lb_n,
   output logic               sram_ub_n
);

   localparam logic [WAIT_W-1:0] CntLoad = WAIT_W'(WAIT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic                last_grant_q, last_grant_d;
   logic                port_q, port_d;
   logic                write_q, write_d;
   logic [SRAM_AW-2:0]  addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          mask_q, mask_d;
   logic [15:0]         rd_lo_q, rd_lo_d;
   logic [31:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                rsp0_q, rsp0_d, rsp1_q, rsp1_d;
   logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
   logic [15:0]         dat_q, dat_d;
   logic                we_en_q, we_en_d;
   logic                cs_n_q, cs_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
   logic                lb_n_q, lb_n_d, ub_n_q, ub_n_d;
   logic [1:0]          grant;
   logic                accept, hi_phase, strobe;

   sram_arb_rr u_rr (
      .req_i        ({p1_cmd_valid, p0_cmd_valid}),
      .last_grant_i (last_grant_q),
      .enable_i     (state_q == StIdle),
      .grant_o      (grant)
   );

   assign p0_cmd_ready = grant[0];
   assign p1_cmd_ready = grant[1];
   assign accept       = |grant;

   // Latch the granted command; fields feed the output logic in the accept cycle.
   always_comb begin
      port_d       = port_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         port_d       = grant[1];
         last_grant_d = grant[1];
         write_d      = grant[1] ? p1_cmd_write : p0_cmd_write;
         addr_d       = grant[1] ? p1_cmd_addr  : p0_cmd_addr;
         wdata_d      = grant[1] ? p1_cmd_wdata : p0_cmd_wdata;
         mask_d       = grant[1] ? p1_cmd_mask  : p0_cmd_mask;
      end
   end

   // State register and strobe counter.
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: phase sequencing with write half-skip.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (write_d && (mask_d[1:0] == 2'b00)) begin
                  state_d = (mask_d[3:2] == 2'b00) ? StResp : StSetupHi;
               end else begin
                  state_d = StSetupLo;
               end
            end
         end
         StSetupLo: begin
            state_d = StStrobeLo;
            cnt_d   = CntLoad;
         end
         StStrobeLo: begin
            if (cnt_q == '0) begin
               state_d = (write_q && (mask_q[3:2] == 2'b00)) ? StResp : StSetupHi;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StSetupHi: begin
            state_d = StStrobeHi;
            cnt_d   = CntLoad;
         end
         StStrobeHi: begin
            if (cnt_q == '0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign hi_phase = (state_d == StSetupHi) || (state_d == StStrobeHi);
   assign strobe   = (state_d == StStrobeLo) || (state_d == StStrobeHi);

   // Output decode from the upcoming state, so pad outputs can be registered.
   always_comb begin
      sram_addr_d = sram_addr_q;
      dat_d       = dat_q;
      we_en_d     = 1'b0;
      cs_n_d      = STROBE_OFF;
      we_n_d      = STROBE_OFF;
      oe_n_d      = STROBE_OFF;
      lb_n_d      = STROBE_OFF;
      ub_n_d      = STROBE_OFF;
      rsp0_d      = 1'b0;
      rsp1_d      = 1'b0;
      rd_lo_d     = rd_lo_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      case (state_d)
         StSetupLo, StStrobeLo, StSetupHi, StStrobeHi: begin
            sram_addr_d = {addr_d, hi_phase};
            cs_n_d      = STROBE_ON;
            if (write_d) begin
               dat_d   = hi_phase ? wdata_d[31:16] : wdata_d[15:0];
               we_en_d = 1'b1;
               lb_n_d  = hi_phase ? !mask_d[2] : !mask_d[0];
               ub_n_d  = hi_phase ? !mask_d[3] : !mask_d[1];
               we_n_d  = !strobe;
            end else begin
               oe_n_d = !strobe;
               lb_n_d = STROBE_ON;
               ub_n_d = STROBE_ON;
            end
         end
         StResp: begin
            rsp0_d = !port_d;
            rsp1_d = port_d;
         end
         default: ;
      endcase
      // Read halves are sampled at the end of the last strobe cycle.
      if ((state_q == StStrobeLo) && (cnt_q == '0)) begin
         rd_lo_d = sram_dat_read;
      end
      if ((state_q == StStrobeHi) && (cnt_q == '0) && !write_q) begin
         if (port_q) begin
            rdata1_d = {sram_dat_read, rd_lo_q};
         end else begin
            rdata0_d = {sram_dat_read, rd_lo_q};
         end
      end
   end

   // Command, read-data and pad output registers.
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         rd_lo_q      <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         rsp0_q       <= 1'b0;
         rsp1_q       <= 1'b0;
         sram_addr_q  <= '0;
         dat_q        <= '0;
         we_en_q      <= 1'b0;
         cs_n_q       <= STROBE_OFF;
         we_n_q       <= STROBE_OFF;
         oe_n_q       <= STROBE_OFF;
         lb_n_q       <= STROBE_OFF;
         ub_n_q       <= STROBE_OFF;
      end else begin
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         rd_lo_q      <= rd_lo_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         rsp0_q       <= rsp0_d;
         rsp1_q       <= rsp1_d;
         sram_addr_q  <= sram_addr_d;
         dat_q        <= dat_d;
         we_en_q      <= we_en_d;
         cs_n_q       <= cs_n_d;
         we_n_q       <= we_n_d;
         oe_n_q       <= oe_n_d;
         lb_n_q       <= lb_n_d;
         ub_n_q       <= ub_n_d;
      end
   end

   assign p0_rsp_valid         = rsp0_q;
   assign p1_rsp_valid         = rsp1_q;
   assign p0_rsp_rdata         = rdata0_q;
   assign p1_rsp_rdata         = rdata1_q;
   assign sram_addr            = sram_addr_q;
   assign sram_dat_write       = dat_q;
   assign sram_dat_writeEnable = we_en_q;
   assign sram_cs_n            = cs_n_q;
   assign sram_we_n            = we_n_q;
   assign sram_oe_n            = oe_n_q;
   assign sram_lb_n            = lb_n_q;
   assign sram_ub_n            = ub_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a word-level golden memory plus a latency/arbitration
// model derived from the access rules, driven by directed and random commands.
module tb_sram_arbiter;

   localparam int unsigned AW   = 18;
   localparam int unsigned WAIT = 1;

   typedef struct packed {
      logic        write;
      logic [16:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } cmd_t;

   logic        CLK, reset_in;
   logic        p0_cmd_valid, p0_cmd_ready, p0_cmd_write, p0_rsp_valid;
   logic [16:0] p0_cmd_addr;
   logic [31:0] p0_cmd_wdata, p0_rsp_rdata;
   logic [3:0]  p0_cmd_mask;
   logic        p1_cmd_valid, p1_cmd_ready, p1_cmd_write, p1_rsp_valid;
   logic [16:0] p1_cmd_addr;
   logic [31:0] p1_cmd_wdata, p1_rsp_rdata;
   logic [3:0]  p1_cmd_mask;
   logic [17:0] sram_addr;
   logic [15:0] sram_dat_read, sram_dat_write;
   logic        sram_dat_writeEnable, sram_cs_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;

   sram_arbiter #(
      .SRAM_AW     (AW),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .CLK                  (CLK),
      .reset_in             (reset_in),
      .p0_cmd_valid         (p0_cmd_valid),
      .p0_cmd_ready         (p0_cmd_ready),
      .p0_cmd_write         (p0_cmd_write),
      .p0_cmd_addr          (p0_cmd_addr),
      .p0_cmd_wdata         (p0_cmd_wdata),
      .p0_cmd_mask          (p0_cmd_mask),
      .p0_rsp_valid         (p0_rsp_valid),
      .p0_rsp_rdata         (p0_rsp_rdata),
      .p1_cmd_valid         (p1_cmd_valid),
      .p1_cmd_ready         (p1_cmd_ready),
      .p1_cmd_write         (p1_cmd_write),
      .p1_cmd_addr          (p1_cmd_addr),
      .p1_cmd_wdata         (p1_cmd_wdata),
      .p1_cmd_mask          (p1_cmd_mask),
      .p1_rsp_valid         (p1_rsp_valid),
      .p1_rsp_rdata         (p1_rsp_rdata),
      .sram_addr            (sram_addr),
      .sram_dat_read        (sram_dat_read),
      .sram_dat_write       (sram_dat_write),
      .sram_dat_writeEnable (sram_dat_writeEnable),
      .sram_cs_n            (sram_cs_n),
      .sram_we_n            (sram_we_n),
      .sram_oe_n            (sram_oe_n),
      .sram_lb_n            (sram_lb_n),
      .sram_ub_n            (sram_ub_n)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Halfword SRAM contents and the word-level golden image.
   logic [15:0] mem [0:(1<<18)-1];
   logic [31:0] gold [0:511];
   assign sram_dat_read = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0, free_cycle = 0, exp_cycle = -1, exp_port = 0;
   int          acc_cyc = 0, last_rsp_cyc = 0;
   logic [31:0] exp_data;
   logic [31:0] lastrd [2];
   logic        last_g = 1'b1;
   bit          pres [2];
   bit          gaps = 1'b0;
   cmd_t        q0 [$];
   cmd_t        q1 [$];
   int          grant_log [$];
   logic [17:0] rd_log [$];
   logic [35:0] wr_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic cmd_t mk(input logic w, input logic [16:0] a, input logic [31:0] d,
                               input logic [3:0] m);
      cmd_t c;
      c.write = w;
      c.addr  = a;
      c.wdata = d;
      c.mask  = m;
      return c;
   endfunction

   // Cycles from acceptance to the response pulse.
   function automatic int lat(input cmd_t c);
      int halves;
      if (!c.write) return 3 + 2 * WAIT;
      halves = int'(c.mask[1:0] != 2'b00) + int'(c.mask[3:2] != 2'b00);
      return 1 + halves * (1 + WAIT);
   endfunction

   // One clock cycle: SRAM model, protocol and response checks, then drive and
   // check the handshake against the arbitration model.
   task automatic step();
      cmd_t       c;
      int         g;
      bit         idle;
      logic [1:0] req;
      logic       e;
      @(negedge CLK);
      cyc++;
      if (!sram_cs_n && !sram_we_n && sram_dat_writeEnable) begin
         if (!sram_lb_n) mem[sram_addr][7:0] = sram_dat_write[7:0];
         if (!sram_ub_n) mem[sram_addr][15:8] = sram_dat_write[15:8];
      end
      if (!sram_we_n) wr_log.push_back({sram_addr, sram_dat_write, sram_lb_n, sram_ub_n});
      if (!sram_oe_n) rd_log.push_back(sram_addr);
      chk("oe_we_exclusive", 32'(!sram_oe_n && !sram_we_n), 32'd0);
      if (sram_dat_writeEnable) chk("drive_needs_cs", 32'(sram_cs_n), 32'd0);
      if (!sram_oe_n) chk("no_drive_while_oe", 32'(sram_dat_writeEnable), 32'd0);
      e = (cyc == exp_cycle) && (exp_port == 0);
      chk("rsp_valid_p0", 32'(p0_rsp_valid), 32'(e));
      if (e) chk("rsp_rdata_p0", p0_rsp_rdata, exp_data);
      e = (cyc == exp_cycle) && (exp_port == 1);
      chk("rsp_valid_p1", 32'(p1_rsp_valid), 32'(e));
      if (e) chk("rsp_rdata_p1", p1_rsp_rdata, exp_data);
      if (p0_rsp_valid || p1_rsp_valid) last_rsp_cyc = cyc;

      if (!pres[0] && q0.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) pres[0] = 1'b1;
      if (!pres[1] && q1.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) pres[1] = 1'b1;
      p0_cmd_valid = pres[0];
      p1_cmd_valid = pres[1];
      if (pres[0]) begin
         c = q0[0];
         p0_cmd_write = c.write; p0_cmd_addr = c.addr; p0_cmd_wdata = c.wdata;
         p0_cmd_mask  = c.mask;
      end
      if (pres[1]) begin
         c = q1[0];
         p1_cmd_write = c.write; p1_cmd_addr = c.addr; p1_cmd_wdata = c.wdata;
         p1_cmd_mask  = c.mask;
      end
      #1;
      idle = (cyc >= free_cycle);
      req  = {pres[1], pres[0]};
      g    = -1;
      if (idle && req != 2'b00) begin
         if (req == 2'b11) g = last_g ? 0 : 1;
         else g = req[1] ? 1 : 0;
      end
      chk("ready_p0", 32'(p0_cmd_ready), 32'(g == 0));
      chk("ready_p1", 32'(p1_cmd_ready), 32'(g == 1));
      if (g >= 0) begin
         if (g == 0) c = q0.pop_front();
         else c = q1.pop_front();
         pres[g]    = 1'b0;
         exp_port   = g;
         exp_cycle  = cyc + lat(c);
         free_cycle = exp_cycle + 1;
         last_g     = (g == 1);
         acc_cyc    = cyc;
         grant_log.push_back(g);
         if (c.write) begin
            exp_data = lastrd[g];
            for (int b = 0; b < 4; b++) begin
               if (c.mask[b]) gold[c.addr][8*b +: 8] = c.wdata[8*b +: 8];
            end
         end else begin
            exp_data  = gold[c.addr];
            lastrd[g] = exp_data;
         end
      end
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || pres[0] || pres[1] || exp_cycle >= cyc)
             && n < limit) begin
         step();
         n++;
      end
      if (n >= limit) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      logic [35:0] w;
      int          n;
      int          gl;
      for (int i = 0; i < 512; i++) begin
         mem[2*i]   = 16'($urandom);
         mem[2*i+1] = 16'($urandom);
         gold[i]    = {mem[2*i+1], mem[2*i]};
      end
      lastrd[0] = '0; lastrd[1] = '0;
      pres[0] = 1'b0; pres[1] = 1'b0;
      reset_in = 1'b1;
      p0_cmd_valid = 0; p0_cmd_write = 0; p0_cmd_addr = '0; p0_cmd_wdata = '0; p0_cmd_mask = '0;
      p1_cmd_valid = 0; p1_cmd_write = 0; p1_cmd_addr = '0; p1_cmd_wdata = '0; p1_cmd_mask = '0;
      @(posedge CLK);
      #1;
      chk("rst_cs_n", 32'(sram_cs_n), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_lb_ub", 32'({sram_lb_n, sram_ub_n}), 32'd3);
      chk("rst_we_en", 32'(sram_dat_writeEnable), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dat", 32'(sram_dat_write), 32'd0);
      chk("rst_rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
      chk("rst_rdata0", p0_rsp_rdata, 32'd0);
      chk("rst_rdata1", p1_rsp_rdata, 32'd0);
      @(negedge CLK);
      reset_in = 1'b0;

      // Directed read on port 0.
      mem[18'h24] = 16'hBEEF; mem[18'h25] = 16'hCAFE; gold[9'h12] = 32'hCAFEBEEF;
      rd_log.delete();
      q0.push_back(mk(1'b0, 17'h12, 32'h0, 4'h0));
      drain(50);
      chk("rd_latency", 32'(last_rsp_cyc - acc_cyc), 32'(3 + 2 * WAIT));
      chk("rd_oe_cycles", 32'(rd_log.size()), 32'(2 * WAIT));
      if (rd_log.size() > 0) begin
         chk("rd_addr_lo", 32'(rd_log[0]), 32'h24);
         chk("rd_addr_hi", 32'(rd_log[rd_log.size()-1]), 32'h25);
      end
      chk("rd_data", p0_rsp_rdata, 32'hCAFEBEEF);

      // Full write on port 1 and read-back.
      wr_log.delete();
      q1.push_back(mk(1'b1, 17'h100, 32'h12345678, 4'hF));
      drain(50);
      chk("wr_we_cycles", 32'(wr_log.size()), 32'(2 * WAIT));
      if (wr_log.size() > 0) begin
         w = wr_log[0];
         chk("wr_lo_addr", 32'(w[35:18]), 32'h200);
         chk("wr_lo_dat", 32'(w[17:2]), 32'h5678);
         chk("wr_lo_lanes", 32'(w[1:0]), 32'd0);
         w = wr_log[wr_log.size()-1];
         chk("wr_hi_addr", 32'(w[35:18]), 32'h201);
         chk("wr_hi_dat", 32'(w[17:2]), 32'h1234);
      end
      q1.push_back(mk(1'b0, 17'h100, 32'h0, 4'h0));
      drain(50);
      chk("wr_readback", p1_rsp_rdata, 32'h12345678);

      // Partial write touching only byte 2: low phase skipped.
      wr_log.delete();
      q0.push_back(mk(1'b1, 17'h20, 32'h00AB0000, 4'b0100));
      drain(50);
      chk("part_latency", 32'(last_rsp_cyc - acc_cyc), 32'(2 + WAIT));
      chk("part_we_cycles", 32'(wr_log.size()), 32'(WAIT));
      if (wr_log.size() > 0) begin
         w = wr_log[0];
         chk("part_addr", 32'(w[35:18]), 32'h41);
         chk("part_lanes", 32'(w[1:0]), 32'b01);
         chk("part_byte", 32'(w[9:2]), 32'hAB);
      end
      q0.push_back(mk(1'b0, 17'h20, 32'h0, 4'h0));
      drain(50);

      // Empty mask still acknowledges, without any SRAM cycle.
      wr_log.delete();
      q1.push_back(mk(1'b1, 17'h21, 32'hFFFFFFFF, 4'h0));
      drain(50);
      chk("nomask_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);
      chk("nomask_no_we", 32'(wr_log.size()), 32'd0);

      // Random traffic on both ports with random gaps.
      gaps = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            q1.push_back(mk(1'($urandom), 17'($urandom_range(0, 15)), $urandom, 4'($urandom)));
         end else begin
            q0.push_back(mk(1'($urandom), 17'($urandom_range(0, 15)), $urandom, 4'($urandom)));
         end
      end
      drain(6000);
      gaps = 1'b0;

      // Reset during the high strobe of a write aborts it at once.
      q1.push_back(mk(1'b1, 17'h40, 32'hA5A55A5A, 4'hF));
      gl = grant_log.size();
      n = 0;
      while (grant_log.size() == gl && n < 20) begin step(); n++; end
      while (cyc < acc_cyc + 3 + int'(WAIT) && n < 40) begin step(); n++; end
      chk("abort_in_strobe_hi", 32'({sram_we_n, sram_addr}), 32'h81);
      reset_in = 1'b1;
      #1;
      chk("abort_cs_n", 32'(sram_cs_n), 32'd1);
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
      chk("abort_we_en", 32'(sram_dat_writeEnable), 32'd0);
      exp_cycle = -1; free_cycle = 0; last_g = 1'b1;
      lastrd[0] = '0; lastrd[1] = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("abort_no_rsp", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
      @(negedge CLK);
      reset_in = 1'b0;

      // Continuous contention after reset alternates, starting with port 0.
      grant_log.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(1'b0, 17'($urandom_range(0, 15)), 32'h0, 4'h0));
         q1.push_back(mk(1'b0, 17'($urandom_range(0, 15)), 32'h0, 4'h0));
      end
      drain(200);
      chk("alt_count", 32'(grant_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
         chk($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for the board's external 16-bit asynchronous SRAM (18-bit halfword address, CS/WE/OE/UB/LB active-low).
- Each port issues 32-bit word reads and writes. The block splits every access into two 16-bit halfword phases, low half first.
- Sits between the SoC-side requesters (port 0: CPU bus bridge; port 1: secondary master, e.g. QSPI/DMA) and the tristate SRAM pad ring. The pads are driven through dat_read / dat_write / dat_writeEnable.

Parameters:
- SRAM_AW, 18, SRAM halfword address width. Word address width is SRAM_AW-1.
- WAIT_CYCLES, 1, strobe-low cycles per halfword phase. Legal range 1..15.

Ports:
- CLK  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset
- p0_cmd_valid / p1_cmd_valid  in  1  request pending
- p0_cmd_ready / p1_cmd_ready  out  1  request accepted this cycle
- p0_cmd_write / p1_cmd_write  in  1  1 = write, 0 = read
- p0_cmd_addr / p1_cmd_addr  in  SRAM_AW-1  word address
- p0_cmd_wdata / p1_cmd_wdata  in  32  write data
- p0_cmd_mask / p1_cmd_mask  in  4  byte enables; bit0 = byte [7:0]
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle completion pulse, for reads and writes
- p0_rsp_rdata / p1_rsp_rdata  out  32  read data, valid with rsp_valid
- sram_addr  out  SRAM_AW  halfword address
- sram_dat_read  in  16  pad input
- sram_dat_write  out  16  pad output
- sram_dat_writeEnable  out  1  pad output enable
- sram_cs_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n  out  1  SRAM strobes, active-low

Behaviour:
- Reset (async, reset_in=1):
  - State = IDLE.
  - All sram_*_n = 1, sram_dat_writeEnable = 0, sram_addr = 0, sram_dat_write = 0.
  - rsp_valid = 0, rsp_rdata = 0, last_grant = 1, so port 0 wins the first contention.
  - Asserting reset mid-access aborts the access immediately. No response is issued.
- Registered outputs: all SRAM outputs come from registers, so the strobes are glitch-free.
- Handshake:
  - cmd_ready is combinational and is high only in IDLE, for the granted port.
  - The transfer occurs when valid && ready.
  - The requester holds valid and its payload stable until ready.
  - Command fields are latched on acceptance.
- Arbitration:
  - Only one port valid → grant it.
  - Both ports valid → grant the port != last_grant.
  - last_grant updates on acceptance.
  - No grant outside IDLE. A request arriving mid-access waits.
- States: IDLE → SETUP_LO → STROBE_LO → SETUP_HI → STROBE_HI → RESP → IDLE.
- SETUP_x (1 cycle):
  - sram_addr = {word_addr, x}, with x = 0 for LO and 1 for HI.
  - cs_n = 0, we_n = oe_n = 1.
  - On writes: sram_dat_write = the wdata half, writeEnable = 1.
- STROBE_x (WAIT_CYCLES cycles, counted by a 4-bit down-counter):
  - Address, data and writeEnable are held.
  - Reads: oe_n = 0. The read half is captured from sram_dat_read on the last strobe cycle.
  - Writes: we_n = 0.
- Byte lanes:
  - Reads: lb_n = ub_n = 0.
  - Writes, LO phase: lb_n = !mask[0], ub_n = !mask[1].
  - Writes, HI phase: lb_n = !mask[2], ub_n = !mask[3].
- Half skip: on a write whose mask pair for a half is 2'b00, that half's SETUP and STROBE states are skipped entirely.
  - LO skip: IDLE → SETUP_HI.
  - HI skip: STROBE_LO → RESP.
  - A write with mask = 0 goes IDLE → RESP and still acknowledges.
- RESP (1 cycle):
  - cs_n = 1, writeEnable = 0.
  - Granted port's rsp_valid = 1; rsp_rdata = {hi, lo} for reads, previous value for writes.
  - Next state is IDLE. A new acceptance can happen in the cycle after RESP.
- Full read latency: acceptance in cycle T → rsp_valid in cycle T+3+2·WAIT_CYCLES. With defaults this is T+5.
- Turnaround: writeEnable drops in RESP, so a read following a write always sees at least one non-driving cycle before oe_n falls.

Decomposition:
- Package sram_arbiter_pkg holds:
  - the state enum;
  - constant WAIT_W = 4;
  - helper constants for the active-low strobe idle value.
- Sub-module sram_arb_rr: 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: grant one-hot.
  - Purely combinational.
- All sequencing stays in sram_arbiter.

Test Plan:
- Read port 0, addr 0x00012, SRAM model holding 0xBEEF @0x24 and 0xCAFE @0x25 → p0_rsp_valid at T+5, rdata = 0xCAFEBEEF. oe_n low exactly 1 cycle per half; sram_addr sequence 0x24, 0x25.
- Write port 1, addr 0x00100, wdata 0x12345678, mask 4'b1111 → we_n low 1 cycle each with dat 0x5678 @0x200 then 0x1234 @0x201. writeEnable=1 only in SETUP/STROBE. Read-back returns 0x12345678.
- Partial write mask 4'b0100, wdata 0x00AB0000 → LO phase skipped. Single HI phase with lb_n=0, ub_n=1. Response at T+3. Neighbouring bytes unchanged.
- Both ports valid continuously for 6 transactions → grants alternate 0,1,0,1,0,1. Each rsp_valid goes only to its own port.
- WAIT_CYCLES=3 build, single read → strobe low 3 cycles per half; rsp at T+9.
- reset_in asserted during STROBE_HI of a write → cs_n, we_n, oe_n return to 1 and writeEnable to 0 within the same cycle (async). No rsp_valid. First post-reset contention is granted to port 0.
